// File: rtl/immediate_encoder.sv
// Packs a 32-bit immediate into RV32 instruction fields selected by select_i, flags
// unrepresentable values and counts errored outputs. Two-entry valid/ready pipeline.
module immediate_encoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       select_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      base_inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_inst_o,
  output logic             range_err_o,
  output logic             align_err_o,
  output logic             sel_err_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] err_count_o
);

  typedef struct packed {
    logic [31:0] inst;
    logic        range_err;
    logic        align_err;
    logic        sel_err;
  } word_t;

  word_t             pk;
  word_t             s1_q, s1_d, s2_q, s2_d;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire, s2_load, sgn;

  assign sgn = ~select_i[3];

  // Stage-1 combinational packing.
  always_comb begin
    pk.inst      = base_inst_i;
    pk.range_err = 1'b0;
    pk.align_err = 1'b0;
    pk.sel_err   = 1'b0;
    unique case (select_i[2:0])
      3'b000: begin
        pk.inst      = {imm_i[31:12], base_inst_i[11:0]};
        pk.range_err = |imm_i[11:0];
      end
      3'b001: begin
        pk.inst      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_inst_i[11:0]};
        pk.range_err = sgn ? ~((&imm_i[31:20]) | ~(|imm_i[31:20])) : |imm_i[31:20];
        pk.align_err = imm_i[0];
      end
      3'b010: begin
        pk.inst      = {imm_i[11:0], base_inst_i[19:0]};
        pk.range_err = sgn ? ~((&imm_i[31:11]) | ~(|imm_i[31:11])) : |imm_i[31:12];
      end
      3'b011: begin
        pk.inst      = {imm_i[12], imm_i[10:5], base_inst_i[24:12], imm_i[4:1], imm_i[11],
                        base_inst_i[6:0]};
        pk.range_err = sgn ? ~((&imm_i[31:12]) | ~(|imm_i[31:12])) : |imm_i[31:13];
        pk.align_err = imm_i[0];
      end
      3'b100: begin
        pk.inst      = {imm_i[11:5], base_inst_i[24:12], imm_i[4:0], base_inst_i[6:0]};
        pk.range_err = sgn ? ~((&imm_i[31:11]) | ~(|imm_i[31:11])) : |imm_i[31:12];
      end
      3'b101: begin
        pk.inst      = {base_inst_i[31:25], imm_i[4:0], base_inst_i[19:0]};
        pk.range_err = |imm_i[31:5];
      end
      default: pk.sel_err = 1'b1;
    endcase
  end

  assign in_ready_o = ~s1_valid_q | ~s2_valid_q | out_ready_i;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = s2_valid_q & out_ready_i;
  assign s2_load    = s1_valid_q & (~s2_valid_q | out_ready_i);

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    if (s2_load) begin
      s2_d       = s1_q;
      s2_valid_d = 1'b1;
      s1_valid_d = 1'b0;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_d       = pk;
      s1_valid_d = 1'b1;
    end
    // Clear has priority over a same-cycle increment.
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (out_fire && (s2_q.range_err || s2_q.align_err || s2_q.sel_err) &&
                 (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_inst_o  = s2_q.inst;
  assign range_err_o = s2_q.range_err;
  assign align_err_o = s2_q.align_err;
  assign sel_err_o   = s2_q.sel_err;
  assign err_count_o = cnt_q;

endmodule
